mult_div_unit: RTL and testbench
================================

# mult_div_unit

Parametrised multi-cycle integer multiply/divide unit for the datapath's arithmetic-logic section. It is the successor to the fixed 32-bit shift-add multiplier. It adds a WIDTH parameter, signed/unsigned multiply, signed/unsigned divide with remainder, and divide-by-zero reporting, all behind a start/done handshake. It produces one result bit per clock and drives the HI/LO result pair consumed by the control unit.

## Interface
- WIDTH, 32, operand width in bits; even, ≥4
- CW, $clog2(WIDTH)+1, width of the iteration counter (derived, not overridden)
- Clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- lhs  in  WIDTH  multiplicand / dividend
- rhs  in  WIDTH  multiplier / divisor
- hi  out  WIDTH  product upper half / remainder
- lo  out  WIDTH  product lower half / quotient
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; hi/lo are valid from this cycle onward
- div_by_zero  out  1  registered with done; high when a DIV/DIVU had rhs==0
- counter  out  CW  iteration count, for debug/control observation

## Operation
- Reset (reset==0, async): state=IDLE; hi, lo, counter = 0; busy, done, div_by_zero = 0; all internal operand registers = 0.
- States: IDLE, RUN, FINISH. busy = (state != IDLE).
- IDLE, start==1:
  - latch op;
  - for signed ops, latch |lhs| and |rhs| and record the signs;
  - clear counter;
  - go to RUN.
  - Exception: DIV/DIVU with rhs==0 goes straight to FINISH with the dbz flag set.
- IDLE, start==0: hold; outputs keep their last values.
- RUN: performs one iteration per cycle, then counter += 1.
  - Multiply: shift-add over the unsigned magnitudes into a 2·WIDTH accumulator.
  - Divide: restoring divide, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
  - After the iteration with counter==WIDTH-1 (counter becomes WIDTH), go to FINISH.
- FINISH: apply the sign correction, write hi/lo, pulse done, set div_by_zero, return to IDLE. counter holds at its final value until the next start.
- Sign rules:
  - MULT: product negated (2·WIDTH two's complement) when the operand signs differ.
  - DIV: quotient negated when the signs differ; remainder takes the sign of lhs.
  - Unsigned ops: no correction.
- Divide by zero: hi = lhs (unmodified), lo = all ones, div_by_zero = 1.
- Signed overflow (DIV of MIN by -1): lo = MIN, hi = 0. No flag is raised.
- start while busy is ignored; no queueing.
- lhs/rhs/op may change freely after the start edge; they are latched.
- div_by_zero and hi/lo hold until the next FINISH. div_by_zero is cleared by the next completion with a nonzero divisor, or by any multiply.

## Timing
- Edge E0: start sampled in IDLE; busy rises after E0.
- Normal op: edges E1..E_WIDTH perform the iterations; edge E_{WIDTH+1} (FINISH) updates hi/lo and sets done=1, busy=0.
  - done is high for exactly the cycle after E_{WIDTH+1}.
  - Latency is WIDTH+1 edges.
- Divide by zero: FINISH at E1, so done is high after E1. Latency is 1 edge.
- Back-to-back operation: start may be asserted in the same cycle done is high. It is accepted at the next edge (state is IDLE), giving a throughput of one operation per WIDTH+2 cycles.
- Reset mid-operation:
  - everything returns to reset values immediately;
  - done is never asserted for the aborted operation;
  - hi/lo read 0.
- No combinational path from inputs to outputs.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32) -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 edges after the start edge, busy high for 33 cycles, counter=32.
- MULT -3 × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> lo=0x7FFFFFFC, hi=1. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU 0x1234 / 0 -> done after 1 edge, div_by_zero=1, hi=0x1234, lo=0xFFFFFFFF. A following MULTU 2×3 clears div_by_zero, lo=6.
- Start DIVU 100/7, pulse start again at cycle 5 (ignored), pull reset low at cycle 10 -> outputs 0, no done. A new DIVU 100/7 then yields lo=14, hi=2.
- Re-run the whole suite with WIDTH=8 and WIDTH=16: MULT -128 × -128 (WIDTH=8) -> hi=0x40, lo=0x00, done 9 edges after start.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Multi-cycle integer multiply/divide unit. It produces one result bit per
// clock and sits behind a start/done handshake.
//   Clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       request, only looked at while idle
//   op          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   lhs, rhs    multiplicand/dividend and multiplier/divisor (latched at start)
//   hi, lo      product upper/lower half, or remainder/quotient
//   busy        high while an operation is in flight
//   done        one-cycle pulse when hi/lo are updated
//   div_by_zero set with done when a divide had a zero divisor
//   counter     iteration count, for observation
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [CW-1:0]    counter
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t state, next_state;

  // Latched operation: op[1] selects divide, op[0] selects unsigned.
  logic             is_div_q;
  logic             dbz_q;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             signed_op;
  logic             lhs_neg;
  logic             rhs_neg;
  logic             rhs_zero;
  logic [WIDTH-1:0] lhs_mag;
  logic [WIDTH-1:0] rhs_mag;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_fits;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand preparation: signed ops work on magnitudes and remember the signs.
  // The magnitude of the most negative value is still correct when read as
  // an unsigned number, so no special case is needed for MIN.
  always_comb begin
    signed_op = ~op[0];
    lhs_neg   = signed_op & lhs[WIDTH-1];
    rhs_neg   = signed_op & rhs[WIDTH-1];
    rhs_zero  = (rhs == '0);
    lhs_mag   = lhs_neg ? -lhs : lhs;
    rhs_mag   = rhs_neg ? -rhs : rhs;
  end

  // One iteration step for each operation.
  // Multiply: {acc_hi, acc_lo} is a right-shifting product register. The
  // multiplier starts in acc_lo and its LSB decides whether to add.
  // Divide: restoring division. The dividend shifts out of acc_lo into the
  // partial remainder in acc_hi, and quotient bits shift into acc_lo.
  always_comb begin
    mul_sum   = acc_hi + {1'b0, (acc_lo[0] ? opnd_q : '0)};
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift - {1'b0, opnd_q};
  end

  // Sign correction applied when the result is written out.
  always_comb begin
    prod     = {acc_hi[WIDTH-1:0], acc_lo};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -acc_lo : acc_lo;
    rem_fix  = neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic. A divide by zero skips the iterations entirely.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (op[1] && rhs_zero) ? FINISH : RUN;
      RUN:     if (counter == LAST_ITER) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath and output registers. hi/lo/div_by_zero change only in FINISH,
  // so they hold their values between operations.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      is_div_q    <= 1'b0;
      dbz_q       <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      opnd_q      <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      counter     <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div_q <= op[1];
            counter  <= '0;
            neg_q    <= lhs_neg ^ rhs_neg;
            neg_r    <= lhs_neg;
            acc_hi   <= '0;
            if (op[1]) begin
              // On a zero divisor acc_lo keeps the raw dividend for hi.
              opnd_q <= rhs_mag;
              acc_lo <= rhs_zero ? lhs : lhs_mag;
              dbz_q  <= rhs_zero;
            end else begin
              opnd_q <= lhs_mag;
              acc_lo <= rhs_mag;
              dbz_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          counter <= counter + 1'b1;
          if (is_div_q) begin
            acc_hi <= div_fits ? div_diff : div_shift;
            acc_lo <= {acc_lo[WIDTH-2:0], div_fits};
          end else begin
            acc_hi <= {1'b0, mul_sum[WIDTH:1]};
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FINISH: begin
          done        <= 1'b1;
          div_by_zero <= dbz_q;
          if (dbz_q) begin
            hi <= acc_lo;
            lo <= '1;
          end else if (is_div_q) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Self-checking bench for mult_div_unit. It instantiates the unit at
// WIDTH = 32, 16 and 8 and runs the same directed and random suite on each.
// Results are compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic Clk = 1'b0;
  logic reset;

  always #5 Clk = ~Clk;

  logic        start_v [3];
  logic [1:0]  op_v    [3];
  logic [31:0] lhs_v   [3];
  logic [31:0] rhs_v   [3];
  logic [31:0] hi_v    [3];
  logic [31:0] lo_v    [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        dbz_v   [3];
  logic [7:0]  cnt_v   [3];

  int checks = 0;
  int errors = 0;

  int          obs_lat;
  logic        obs_busy_e0, obs_busy_gap, obs_busy_end, obs_done_after, obs_dbz;
  logic [31:0] obs_hi, obs_lo;
  logic [7:0]  obs_cnt;

  // One DUT per width. Narrow outputs are zero-extended onto common buses.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W  = (g == 0) ? 32 : (g == 1) ? 16 : 8;
    localparam int CW = $clog2(W) + 1;
    logic [W-1:0]  hi_w, lo_w;
    logic [CW-1:0] cnt_w;
    mult_div_unit #(.WIDTH(W)) dut (
      .Clk(Clk), .reset(reset), .start(start_v[g]), .op(op_v[g]),
      .lhs(lhs_v[g][W-1:0]), .rhs(rhs_v[g][W-1:0]),
      .hi(hi_w), .lo(lo_w), .busy(busy_v[g]), .done(done_v[g]),
      .div_by_zero(dbz_v[g]), .counter(cnt_w)
    );
    assign hi_v[g]  = 32'(hi_w);
    assign lo_v[g]  = 32'(lo_w);
    assign cnt_v[g] = 8'(cnt_w);
  end

  function automatic int widthOf(input int k);
    return (k == 0) ? 32 : (k == 1) ? 16 : 8;
  endfunction

  // Reference model: signed values are interpreted at width w and the
  // result is computed with 64-bit arithmetic, then split into hi/lo.
  function automatic void refModel(input int w, input logic [1:0] o,
                                   input logic [31:0] a_in, input logic [31:0] b_in,
                                   output logic [31:0] e_hi, output logic [31:0] e_lo,
                                   output logic e_dbz);
    longint unsigned mask, ua, ub, pu;
    longint sa, sb;
    mask  = (64'd1 << w) - 64'd1;
    ua    = {32'd0, a_in} & mask;
    ub    = {32'd0, b_in} & mask;
    sa    = (ua >= (64'd1 << (w - 1))) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb    = (ub >= (64'd1 << (w - 1))) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    e_dbz = 1'b0;
    pu    = 64'd0;
    case (o)
      2'b00: pu = longint'(sa * sb);
      2'b01: pu = ua * ub;
      default: ;
    endcase
    if (!o[1]) begin
      e_hi = 32'((pu >> w) & mask);
      e_lo = 32'(pu & mask);
    end else if (ub == 64'd0) begin
      e_hi  = 32'(ua);
      e_lo  = 32'(mask);
      e_dbz = 1'b1;
    end else if (o == 2'b10) begin
      e_hi = 32'(longint'(sa % sb) & mask);
      e_lo = 32'(longint'(sa / sb) & mask);
    end else begin
      e_hi = 32'((ua % ub) & mask);
      e_lo = 32'((ua / ub) & mask);
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one operation on DUT k and watches it until done (bounded).
  // The inputs are scrambled right after the start edge, and a stray start
  // pulse is sent mid-operation, which the DUT must ignore.
  task automatic applyStimulus(input int k, input logic [1:0] o,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    start_v[k] = 1'b1; op_v[k] = o; lhs_v[k] = a; rhs_v[k] = b;
    @(posedge Clk); #1;
    obs_busy_e0 = busy_v[k];
    start_v[k] = 1'b0; op_v[k] = 2'($urandom); lhs_v[k] = $urandom; rhs_v[k] = $urandom;
    obs_lat = 0;
    obs_busy_gap = 1'b0;
    while (done_v[k] !== 1'b1 && obs_lat < 200) begin
      @(posedge Clk); #1;
      obs_lat++;
      if (done_v[k] !== 1'b1 && busy_v[k] !== 1'b1) obs_busy_gap = 1'b1;
      start_v[k] = (obs_lat == 2);
    end
    start_v[k]   = 1'b0;
    obs_busy_end = busy_v[k];
    obs_hi       = hi_v[k];
    obs_lo       = lo_v[k];
    obs_dbz      = dbz_v[k];
    obs_cnt      = cnt_v[k];
    @(posedge Clk); #1;
    obs_done_after = done_v[k];
  endtask

  task automatic runOp(input int k, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int w;
    logic [31:0] e_hi, e_lo;
    logic e_dbz;
    string t;
    w = widthOf(k);
    t = $sformatf("w%0d op%0d %h,%h", w, o, a, b);
    refModel(w, o, a, b, e_hi, e_lo, e_dbz);
    applyStimulus(k, o, a, b);
    checkOutput({t, " hi"},      64'(obs_hi), 64'(e_hi));
    checkOutput({t, " lo"},      64'(obs_lo), 64'(e_lo));
    checkOutput({t, " dbz"},     64'(obs_dbz), 64'(e_dbz));
    checkOutput({t, " latency"}, 64'(obs_lat), e_dbz ? 64'd1 : 64'(w + 1));
    checkOutput({t, " counter"}, 64'(obs_cnt), e_dbz ? 64'd0 : 64'(w));
    checkOutput({t, " busy_e0"}, 64'(obs_busy_e0), 64'd1);
    checkOutput({t, " busy_gap"}, 64'(obs_busy_gap), 64'd0);
    checkOutput({t, " busy_end"}, 64'(obs_busy_end), 64'd0);
    checkOutput({t, " done_pulse"}, 64'(obs_done_after), 64'd0);
  endtask

  task automatic checkZero(input int k, input string t);
    checkOutput({t, " hi"},      64'(hi_v[k]), 64'd0);
    checkOutput({t, " lo"},      64'(lo_v[k]), 64'd0);
    checkOutput({t, " busy"},    64'(busy_v[k]), 64'd0);
    checkOutput({t, " done"},    64'(done_v[k]), 64'd0);
    checkOutput({t, " dbz"},     64'(dbz_v[k]), 64'd0);
    checkOutput({t, " counter"}, 64'(cnt_v[k]), 64'd0);
  endtask

  // DIVU 100/7 aborted by reset before it can finish, after an ignored
  // second start. The narrow unit is aborted earlier so that it is still
  // mid-operation when reset hits.
  task automatic resetAbort(input int k);
    int w, pulse_at, rst_at;
    logic saw_done;
    w        = widthOf(k);
    pulse_at = (w > 10) ? 5 : 3;
    rst_at   = (w > 10) ? 10 : 6;
    saw_done = 1'b0;
    @(negedge Clk);
    start_v[k] = 1'b1; op_v[k] = 2'b11; lhs_v[k] = 32'd100; rhs_v[k] = 32'd7;
    @(posedge Clk); #1;
    start_v[k] = 1'b0;
    for (int c = 1; c <= rst_at; c++) begin
      @(posedge Clk); #1;
      if (done_v[k]) saw_done = 1'b1;
      start_v[k] = (c == pulse_at);
      if (c == pulse_at) begin
        op_v[k] = 2'b01; lhs_v[k] = $urandom; rhs_v[k] = $urandom;
      end
    end
    start_v[k] = 1'b0;
    @(negedge Clk);
    reset = 1'b0;
    #1;
    checkZero(k, $sformatf("w%0d abort", w));
    @(negedge Clk);
    reset = 1'b1;
    repeat (3) begin
      @(posedge Clk); #1;
      if (done_v[k] || busy_v[k]) saw_done = 1'b1;
    end
    checkOutput($sformatf("w%0d abort no_done", w), 64'(saw_done), 64'd0);
    runOp(k, 2'b11, 32'd100, 32'd7);
  endtask

  initial begin
    int w;
    logic [31:0] mn, mk, a, b;
    logic [1:0] o;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; op_v[k] = 2'b00; lhs_v[k] = '0; rhs_v[k] = '0;
    end
    repeat (3) @(posedge Clk);
    #1;
    for (int k = 0; k < 3; k++) checkZero(k, $sformatf("w%0d reset", widthOf(k)));
    @(negedge Clk);
    reset = 1'b1;

    for (int k = 0; k < 3; k++) begin
      w  = widthOf(k);
      mn = 32'(64'd1 << (w - 1));
      mk = 32'((64'd1 << w) - 64'd1);
      $display("[TB] suite for WIDTH=%0d", w);
      runOp(k, 2'b01, mk, mk);
      runOp(k, 2'b00, 32'hFFFF_FFFD, 32'd7);
      runOp(k, 2'b00, mn, mn);
      runOp(k, 2'b10, 32'hFFFF_FFF9, 32'd2);
      runOp(k, 2'b11, 32'hFFFF_FFF9, 32'd2);
      runOp(k, 2'b10, mn, 32'hFFFF_FFFF);
      runOp(k, 2'b11, 32'h0000_1234, 32'd0);
      runOp(k, 2'b01, 32'd2, 32'd3);
      runOp(k, 2'b10, 32'hFFFF_FF9C, 32'd0);
      runOp(k, 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
      resetAbort(k);
      for (int r = 0; r < 12; r++) begin
        o = 2'($urandom);
        a = $urandom;
        b = $urandom;
        if ($urandom_range(0, 5) == 0) b = 32'd0;
        else if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 9));
        runOp(k, o, a, b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
